// File: rtl/ofdm_rx_output_buffer.sv
// OFDM receive output buffer: AXI4-Stream words queued with frame markers in a FIFO,
// drained by the processor through an AXI4 read-burst slave with a fill/frame status window.
module ofdm_rx_output_buffer #(
    parameter int C_S00_AXI_ID_WIDTH     = 1,
    parameter int C_S00_AXI_DATA_WIDTH   = 32,
    parameter int C_S00_AXI_ADDR_WIDTH   = 13,
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int DEPTH_LOG2             = 8
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                              s00_axis_tlast,
    input  logic                              s00_axis_tvalid,
    output logic                              s00_axis_tready,
    input  logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_arid,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [7:0]                        s00_axi_arlen,
    input  logic [2:0]                        s00_axi_arsize,
    input  logic [1:0]                        s00_axi_arburst,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_rid,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rlast,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic                              frame_irq
);

    localparam int          DEPTH   = 2 ** DEPTH_LOG2;
    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_t;

    rd_state_t state, stateNext;

    logic [32:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr, rdPtr;
    logic [15:0]           fillLevel, fillNext, framesPending;
    logic [32:0]           headEntry;
    logic                  axisReady, push, pop, load;
    logic                  arHandshake, rHandshake;

    logic                              arreadyQ, rvalidQ, rlastQ, irqQ;
    logic [C_S00_AXI_ID_WIDTH-1:0]     ridQ;
    logic [C_S00_AXI_DATA_WIDTH-1:0]   rdataQ, loadData;
    logic [1:0]                        rrespQ, loadResp;
    logic [7:0]                        lenQ, beatCnt;
    logic                              regionQ, sizeErrQ;

    // Only araddr[12] selects the region; the offset and burst type have no effect.
    logic unusedInputs;
    assign unusedInputs = &{1'b0, s00_axi_araddr, s00_axi_arburst};

    assign push        = s00_axis_tvalid & axisReady;
    assign headEntry   = mem[rdPtr];
    assign fillNext    = fillLevel + 16'(push) - 16'(pop);
    assign arHandshake = s00_axi_arvalid & arreadyQ;
    assign rHandshake  = rvalidQ & s00_axi_rready;

    // NOTE: the FIFO storage carries no reset; validity is tracked by the pointers and fill level.
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem[wrPtr] <= {s00_axis_tlast, s00_axis_tdata};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wrPtr         <= '0;
            rdPtr         <= '0;
            fillLevel     <= '0;
            framesPending <= '0;
            axisReady     <= 1'b0;
            irqQ          <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            fillLevel     <= fillNext;
            axisReady     <= (fillNext != DEPTH_W);
            framesPending <= framesPending + 16'(push & s00_axis_tlast)
                                           - 16'(pop & headEntry[32]);
            irqQ          <= push & s00_axis_tlast;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        stateNext = state;
        load      = 1'b0;
        pop       = 1'b0;
        loadData  = '0;
        loadResp  = 2'b00;
        case (state)
            IDLE: begin
                if (arHandshake) stateNext = BURST;
            end
            BURST: begin
                if (rHandshake && rlastQ) begin
                    stateNext = IDLE;
                end else if (!rvalidQ || rHandshake) begin
                    if (sizeErrQ) begin
                        load     = 1'b1;
                        loadResp = 2'b10;
                    end else if (regionQ) begin
                        load     = 1'b1;
                        loadData = {framesPending, fillLevel};
                    end else if (fillLevel != 16'd0) begin
                        load     = 1'b1;
                        pop      = 1'b1;
                        loadData = headEntry[31:0];
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // R output register: holds the current beat until it handshakes.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            arreadyQ <= 1'b0;
            ridQ     <= '0;
            lenQ     <= '0;
            regionQ  <= 1'b0;
            sizeErrQ <= 1'b0;
            beatCnt  <= '0;
            rvalidQ  <= 1'b0;
            rdataQ   <= '0;
            rrespQ   <= 2'b00;
            rlastQ   <= 1'b0;
        end else begin
            arreadyQ <= (stateNext == IDLE);
            if (arHandshake) begin
                ridQ     <= s00_axi_arid;
                lenQ     <= s00_axi_arlen;
                regionQ  <= s00_axi_araddr[12];
                sizeErrQ <= (s00_axi_arsize != 3'b010);
                beatCnt  <= '0;
            end
            if (load) begin
                rvalidQ <= 1'b1;
                rdataQ  <= loadData;
                rrespQ  <= loadResp;
                rlastQ  <= (beatCnt == lenQ);
                beatCnt <= beatCnt + 8'd1;
            end else if (rHandshake) begin
                rvalidQ <= 1'b0;
                rlastQ  <= 1'b0;
            end
        end
    end

    assign s00_axis_tready = axisReady;
    assign s00_axi_arready = arreadyQ;
    assign s00_axi_rid     = ridQ;
    assign s00_axi_rdata   = rdataQ;
    assign s00_axi_rresp   = rrespQ;
    assign s00_axi_rlast   = rlastQ;
    assign s00_axi_rvalid  = rvalidQ;
    assign frame_irq       = irqQ;

endmodule

// File: tb/tb_ofdm_rx_output_buffer.sv
// Directed bench for ofdm_rx_output_buffer: a deep instance and a 4-entry instance share one
// stimulus set; read beats are scored against an expected-beat queue filled as stimulus is driven.
module tb_ofdm_rx_output_buffer;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic tb_ACLK    = 1'b0;
    logic tb_ARESETN = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    logic [31:0] tdata   = '0;
    logic        tlast   = 1'b0;
    logic        tvalid  = 1'b0;
    logic [0:0]  arid    = '0;
    logic [12:0] araddr  = '0;
    logic [7:0]  arlen   = '0;
    logic [2:0]  arsize  = 3'b010;
    logic [1:0]  arburst = 2'b01;
    logic        arvalid = 1'b0;
    logic        rready  = 1'b1;
    logic        useSmall = 1'b0;

    logic        treadyB, arreadyB, rlastB, rvalidB, irqB;
    logic [0:0]  ridB;
    logic [31:0] rdataB;
    logic [1:0]  rrespB;
    logic        treadyS, arreadyS, rlastS, rvalidS, irqS;
    logic [0:0]  ridS;
    logic [31:0] rdataS;
    logic [1:0]  rrespS;

    logic        treadySel, arreadySel, rlastSel, rvalidSel;
    logic [0:0]  ridSel;
    logic [31:0] rdataSel;
    logic [1:0]  rrespSel;
    assign treadySel  = useSmall ? treadyS  : treadyB;
    assign arreadySel = useSmall ? arreadyS : arreadyB;
    assign rlastSel   = useSmall ? rlastS   : rlastB;
    assign rvalidSel  = useSmall ? rvalidS  : rvalidB;
    assign ridSel     = useSmall ? ridS     : ridB;
    assign rdataSel   = useSmall ? rdataS   : rdataB;
    assign rrespSel   = useSmall ? rrespS   : rrespB;

    ofdm_rx_output_buffer #(.DEPTH_LOG2(8)) dut (
        .ACLK(tb_ACLK), .ARESETN(tb_ARESETN),
        .s00_axis_tdata(tdata), .s00_axis_tlast(tlast),
        .s00_axis_tvalid(tvalid & !useSmall), .s00_axis_tready(treadyB),
        .s00_axi_arid(arid), .s00_axi_araddr(araddr), .s00_axi_arlen(arlen),
        .s00_axi_arsize(arsize), .s00_axi_arburst(arburst),
        .s00_axi_arvalid(arvalid & !useSmall), .s00_axi_arready(arreadyB),
        .s00_axi_rid(ridB), .s00_axi_rdata(rdataB), .s00_axi_rresp(rrespB),
        .s00_axi_rlast(rlastB), .s00_axi_rvalid(rvalidB),
        .s00_axi_rready(rready & !useSmall), .frame_irq(irqB)
    );

    ofdm_rx_output_buffer #(.DEPTH_LOG2(2)) dutSmall (
        .ACLK(tb_ACLK), .ARESETN(tb_ARESETN),
        .s00_axis_tdata(tdata), .s00_axis_tlast(tlast),
        .s00_axis_tvalid(tvalid & useSmall), .s00_axis_tready(treadyS),
        .s00_axi_arid(arid), .s00_axi_araddr(araddr), .s00_axi_arlen(arlen),
        .s00_axi_arsize(arsize), .s00_axi_arburst(arburst),
        .s00_axi_arvalid(arvalid & useSmall), .s00_axi_arready(arreadyS),
        .s00_axi_rid(ridS), .s00_axi_rdata(rdataS), .s00_axi_rresp(rrespS),
        .s00_axi_rlast(rlastS), .s00_axi_rvalid(rvalidS),
        .s00_axi_rready(rready & useSmall), .frame_irq(irqS)
    );

    int          errors   = 0;
    int          checks   = 0;
    int          irqCount = 0;
    logic [32:0] modelB[$];
    logic [32:0] modelS[$];
    beat_t       expQ[$];

    always @(negedge tb_ACLK) if (irqB === 1'b1) irqCount++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic streamWord(input logic [31:0] d, input logic l, input bit toModel);
        int n;
        n = 0;
        @(negedge tb_ACLK);
        tdata  = d;
        tlast  = l;
        tvalid = 1'b1;
        while (!treadySel && n < 200) begin
            @(negedge tb_ACLK);
            n++;
        end
        if (n >= 200) check("tready timeout", 0, 1);
        @(posedge tb_ACLK);
        #1;
        tvalid = 1'b0;
        if (toModel) begin
            if (useSmall) modelS.push_back({l, d});
            else          modelB.push_back({l, d});
        end
    endtask

    task automatic issueRead(input logic [0:0] id, input logic [12:0] addr,
                             input logic [7:0] len, input logic [2:0] size);
        int n;
        n = 0;
        @(negedge tb_ACLK);
        arid    = id;
        araddr  = addr;
        arlen   = len;
        arsize  = size;
        arvalid = 1'b1;
        while (!arreadySel && n < 100) begin
            @(negedge tb_ACLK);
            n++;
        end
        if (n >= 100) check("arready timeout", 0, 1);
        @(posedge tb_ACLK);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic expectData(input int n);
        logic [32:0] e;
        for (int i = 0; i < n; i++) begin
            if (useSmall) e = modelS.pop_front();
            else          e = modelB.pop_front();
            expQ.push_back(beat_t'{data: e[31:0], resp: 2'b00, last: (i == n - 1)});
        end
    endtask

    task automatic expectErr(input int n);
        for (int i = 0; i < n; i++)
            expQ.push_back(beat_t'{data: 32'h0, resp: 2'b10, last: (i == n - 1)});
    endtask

    task automatic collect(input int n, input logic [0:0] id, input int stallAt, input int abortAt);
        int    beat;
        int    idle;
        beat_t e;
        beat = 0;
        idle = 0;
        while (beat < n) begin
            @(negedge tb_ACLK);
            if (rvalidSel) begin
                idle = 0;
                if (expQ.size() == 0) begin
                    check("scoreboard underflow", 1, 0);
                    return;
                end
                e = expQ[0];
                if (beat == stallAt) begin
                    rready = 1'b0;
                    for (int k = 0; k < 5; k++) begin
                        check($sformatf("stall cycle%0d hold", k),
                              {rvalidSel, rdataSel, rlastSel, ridSel}, {1'b1, e.data, e.last, id});
                        @(negedge tb_ACLK);
                    end
                    rready = 1'b1;
                end
                e = expQ.pop_front();
                check($sformatf("beat%0d rdata", beat), rdataSel, e.data);
                check($sformatf("beat%0d rresp", beat), rrespSel, e.resp);
                check($sformatf("beat%0d rlast", beat), rlastSel, e.last);
                check($sformatf("beat%0d rid", beat), ridSel, id);
                if (beat == abortAt) return;
                beat++;
            end else begin
                idle++;
                if (idle > 100) begin
                    check("rvalid timeout", 0, 1);
                    return;
                end
            end
        end
    endtask

    task automatic readStatus(input logic [31:0] expWord, input logic [0:0] id);
        expQ.push_back(beat_t'{data: expWord, resp: 2'b00, last: 1'b1});
        issueRead(id, 13'h1000, 8'd0, 3'b010);
        collect(1, id, -1, -1);
    endtask

    initial begin
        repeat (3) @(negedge tb_ACLK);
        check("reset arready", arreadyB, 0);
        check("reset tready", treadyB, 0);
        check("reset rvalid", rvalidB, 0);
        check("reset rdata", rdataB, 0);
        check("reset irq", irqB, 0);
        tb_ARESETN = 1'b1;
        @(negedge tb_ACLK);
        check("release arready", arreadyB, 1);
        check("release tready", treadyB, 1);

        // 1: one 16-word frame read back as a single burst
        for (int i = 1; i <= 16; i++) streamWord(32'(i), (i == 16), 1'b1);
        repeat (2) @(negedge tb_ACLK);
        check("t1 irq count", irqCount, 1);
        expectData(16);
        issueRead(1'b1, 13'h0000, 8'd15, 3'b010);
        collect(16, 1'b1, -1, -1);
        readStatus(32'h0000_0000, 1'b0);

        // 2: frame accounting through the status window
        for (int i = 1; i <= 5; i++) streamWord(32'h20 + 32'(i), (i == 3 || i == 5), 1'b1);
        repeat (2) @(negedge tb_ACLK);
        check("t2 irq count", irqCount, 3);
        readStatus(32'h0002_0005, 1'b0);
        expectData(3);
        issueRead(1'b0, 13'h0000, 8'd2, 3'b010);
        collect(3, 1'b0, -1, -1);
        readStatus(32'h0001_0002, 1'b1);
        expectData(2);
        issueRead(1'b0, 13'h0000, 8'd1, 3'b010);
        collect(2, 1'b0, -1, -1);

        // 3: backpressure on the 4-entry instance
        useSmall = 1'b1;
        fork
            for (int i = 1; i <= 6; i++) streamWord(32'(i), 1'b0, 1'b1);
            begin
                repeat (12) @(negedge tb_ACLK);
                check("t3 tready low when full", treadyS, 0);
                check("t3 words accepted", modelS.size(), 4);
                expectData(2);
                issueRead(1'b1, 13'h0000, 8'd1, 3'b010);
                collect(2, 1'b1, -1, -1);
            end
        join
        expectData(4);
        issueRead(1'b1, 13'h0000, 8'd3, 3'b010);
        collect(4, 1'b1, -1, -1);
        @(negedge tb_ACLK);
        check("t3 tready after drain", treadyS, 1);
        useSmall = 1'b0;

        // 4: burst issued on an empty FIFO stalls until each word lands
        for (int i = 0; i < 4; i++)
            expQ.push_back(beat_t'{data: 32'hA0 + 32'(i), resp: 2'b00, last: (i == 3)});
        fork
            begin
                issueRead(1'b0, 13'h0000, 8'd3, 3'b010);
                collect(4, 1'b0, -1, -1);
            end
            for (int i = 0; i < 4; i++) begin
                repeat (3) @(negedge tb_ACLK);
                check($sformatf("t4 rvalid low before word%0d", i), rvalidB, 0);
                streamWord(32'hA0 + 32'(i), 1'b0, 1'b0);
            end
        join

        // 5: rready stall mid-burst, then a bad-size burst
        for (int i = 0; i < 6; i++) streamWord(32'hB0 + 32'(i), (i == 3), 1'b1);
        expectData(4);
        issueRead(1'b1, 13'h0000, 8'd3, 3'b010);
        collect(4, 1'b1, 1, -1);
        readStatus(32'h0000_0002, 1'b0);
        expectErr(3);
        issueRead(1'b1, 13'h0000, 8'd2, 3'b011);
        collect(3, 1'b1, -1, -1);
        readStatus(32'h0000_0002, 1'b1);

        // 6: reset during beat 2 of an 8-beat burst with 10 words queued
        for (int i = 0; i < 8; i++) streamWord(32'hC0 + 32'(i), 1'b0, 1'b1);
        readStatus(32'h0000_000A, 1'b0);
        expectData(8);
        issueRead(1'b0, 13'h0000, 8'd7, 3'b010);
        collect(8, 1'b0, -1, 1);
        tb_ARESETN = 1'b0;
        #1;
        check("t6 reset rvalid", rvalidB, 0);
        check("t6 reset rdata", rdataB, 0);
        check("t6 reset rlast", rlastB, 0);
        check("t6 reset arready", arreadyB, 0);
        check("t6 reset tready", treadyB, 0);
        modelB.delete();
        expQ.delete();
        repeat (2) @(negedge tb_ACLK);
        tb_ARESETN = 1'b1;
        @(negedge tb_ACLK);
        check("t6 release arready", arreadyB, 1);
        check("t6 release tready", treadyB, 1);
        readStatus(32'h0000_0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
